// File: rtl/fetch_controller_if.sv
// Instruction-memory and execute-stage handshake bundle for fetch_controller.
// master = fetch sequencer, slave = memory plus execute stage.
interface fetch_controller_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] instr0;
  logic [DATA_WIDTH-1:0] instr1;
  logic                  instr_valid;
  logic                  ex_ack;
  logic                  jump_valid;
  logic [ADDR_WIDTH-1:0] jump_addr;

  modport master (
    output mem_req, mem_addr, instr0, instr1, instr_valid,
    input  mem_ready, mem_data, ex_ack, jump_valid, jump_addr
  );

  modport slave (
    input  mem_req, mem_addr, instr0, instr1, instr_valid,
    output mem_ready, mem_data, ex_ack, jump_valid, jump_addr
  );
endinterface

// File: rtl/fetch_controller.sv
// Fetch/decode sequencer: fetches one- or two-word instructions, offers them to execute
// with a valid/ack handshake, takes jumps on ack and halts on END.
module fetch_controller #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           CR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [7:0]            LIMM_OP    = 8'h02,
  parameter logic [7:0]            END_OP     = 8'hF0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fetch_controller_if.master    bus,
  output logic [3:0]            current_state_o,
  output logic [CR_WIDTH-1:0]   cr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  halted_o
);

  localparam logic [3:0] StFetch0 = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StFetch1 = 4'd2;
  localparam logic [3:0] StExec   = 4'd3;
  localparam logic [3:0] StHalt   = 4'd4;

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
  logic [DATA_WIDTH-1:0] instr0_q, instr0_d;
  logic [DATA_WIDTH-1:0] instr1_q, instr1_d;
  logic [1:0]            cr_q, cr_d;
  logic [7:0]            opcode;

  assign opcode = instr0_q[DATA_WIDTH-1 -: 8];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iaddr_d  = iaddr_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    cr_d     = cr_q;
    case (state_q)
      StFetch0: begin
        if (bus.mem_ready) begin
          instr0_d = bus.mem_data;
          iaddr_d  = pc_q;
          pc_d     = pc_q + ADDR_WIDTH'(1);
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (opcode == END_OP) begin
          cr_d[0] = 1'b1;
          state_d = StHalt;
        end else if (opcode == LIMM_OP) begin
          state_d = StFetch1;
        end else begin
          instr1_d = '0;
          state_d  = StExec;
        end
      end
      StFetch1: begin
        if (bus.mem_ready) begin
          instr1_d = bus.mem_data;
          pc_d     = pc_q + ADDR_WIDTH'(1);
          state_d  = StExec;
        end
      end
      StExec: begin
        if (bus.ex_ack) begin
          if (bus.jump_valid) begin
            pc_d = bus.jump_addr;
            // Jumping back to the instruction itself: flag a self-loop.
            if (bus.jump_addr == iaddr_q) begin
              cr_d[1] = 1'b1;
            end
          end
          state_d = StFetch0;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StFetch0;
      pc_q     <= RESET_PC;
      iaddr_q  <= RESET_PC;
      instr0_q <= '0;
      instr1_q <= '0;
      cr_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      iaddr_q  <= iaddr_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      cr_q     <= cr_d;
    end
  end

  assign bus.mem_req     = (state_q == StFetch0) || (state_q == StFetch1);
  assign bus.mem_addr    = pc_q;
  assign bus.instr0      = instr0_q;
  assign bus.instr1      = instr1_q;
  assign bus.instr_valid = (state_q == StExec);
  assign halted_o        = (state_q == StHalt);
  assign current_state_o = state_q;
  assign pc_o            = pc_q;

  always_comb begin
    cr_o      = '0;
    cr_o[1:0] = cr_q;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: vector table, directed corner sequences and a
// randomized instruction stream checked against a transaction-level model.
module tb_fetch_controller;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic clk;
  logic rst_n;

  fetch_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  fetch_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_w ();

  logic [3:0]    state, state_w;
  logic [CW-1:0] cr, cr_w;
  logic [AW-1:0] pc, pc_w;
  logic          halted, halted_w;

  fetch_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CR_WIDTH(CW), .RESET_PC(16'h0000),
    .LIMM_OP(8'h02), .END_OP(8'hF0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.master), .current_state_o(state),
    .cr_o(cr), .pc_o(pc), .halted_o(halted)
  );

  fetch_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CR_WIDTH(CW), .RESET_PC(16'hFFFF),
    .LIMM_OP(8'h02), .END_OP(8'hF0)
  ) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_w.master), .current_state_o(state_w),
    .cr_o(cr_w), .pc_o(pc_w), .halted_o(halted_w)
  );

  assign bus_w.mem_ready  = 1'b1;
  assign bus_w.mem_data   = 32'h0100_0000;
  assign bus_w.ex_ack     = 1'b1;
  assign bus_w.jump_valid = 1'b0;
  assign bus_w.jump_addr  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [65536];
  int n_chk;
  int n_fail;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          w0c;
    int          w1c;
    int          ack;
    bit          jv;
    logic [15:0] ja;
    logic [31:0] e_i0;
    logic [31:0] e_i1;
    int          e_cyc;
    logic [15:0] e_pc;
    logic [7:0]  e_cr;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_ready  = 1'b0;
    bus.mem_data   = '0;
    bus.ex_ack     = 1'b0;
    bus.jump_valid = 1'b0;
    bus.jump_addr  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_state", state, 4'd0);
    chk("rst_instr0", bus.instr0, 32'h0);
    chk("rst_instr1", bus.instr1, 32'h0);
    chk("rst_cr", cr, 8'h00);
    chk("rst_mem_req", bus.mem_req, 1'b1);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
  endtask

  // Drives one instruction from FETCH0 through the accepting ack, checking as it goes.
  task automatic do_instr(input logic [15:0] start, input int w0c, input int w1c,
                          input int ack, input bit jv, input logic [15:0] ja,
                          input logic [31:0] e_i0, input logic [31:0] e_i1, input int e_cyc,
                          input logic [15:0] e_pc, input logic [7:0] e_cr);
    int cyc = 0;
    int fetches = 0;
    int wcnt = w0c;
    int acnt = ack;
    bit done = 1'b0;
    logic [15:0] ea;
    while (!done && cyc < 200) begin
      bus.mem_ready  = 1'b0;
      bus.mem_data   = $urandom;
      bus.ex_ack     = 1'b0;
      bus.jump_valid = 1'b0;
      bus.jump_addr  = 16'($urandom);
      if (bus.mem_req) begin
        ea = start + 16'(fetches);
        chk("mem_addr", bus.mem_addr, ea);
        if (fetches == 1) chk("fetch1_state", state, 4'd2);
        if (wcnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_data  = mem[ea];
          fetches++;
          wcnt = w1c;
        end else begin
          wcnt--;
        end
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      if (bus.instr_valid) begin
        chk("instr0", bus.instr0, e_i0);
        chk("instr1", bus.instr1, e_i1);
        if (acnt == 0) begin
          bus.ex_ack     = 1'b1;
          bus.jump_valid = jv;
          bus.jump_addr  = ja;
          done = 1'b1;
        end else begin
          acnt--;
          bus.jump_valid = 1'b1;
        end
      end
      step();
      cyc++;
    end
    chk("ack_seen", done, 1'b1);
    chk("cycles", cyc, e_cyc);
    chk("pc_after", pc, e_pc);
    chk("next_mem_addr", bus.mem_addr, e_pc);
    chk("next_mem_req", bus.mem_req, 1'b1);
    chk("valid_dropped", bus.instr_valid, 1'b0);
    chk("cr", cr, e_cr);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [15:0] mpc, ja, npc;
    logic [7:0]  mcr;
    logic [31:0] i1;
    bit          two, jv;
    int          w0, w1, ak, ecyc;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Program words never carry END; a third of them are LIMM.
    for (int i = 0; i < 65536; i++) begin
      w = $urandom;
      if ($urandom_range(0, 2) == 0) w[31:24] = 8'h02;
      else if (w[31:24] == 8'hF0 || w[31:24] == 8'h02) w[31:24] = 8'h11;
      mem[i] = w;
    end

    vecs[0] = '{32'h0100_0000, 32'h0, 0, 0, 0, 1'b0, 16'h0000,
                32'h0100_0000, 32'h0, 3, 16'h0001, 8'h00};
    vecs[1] = '{32'h0200_0005, 32'h0000_ABCD, 0, 0, 0, 1'b0, 16'h0000,
                32'h0200_0005, 32'h0000_ABCD, 4, 16'h0002, 8'h00};
    vecs[2] = '{32'h0100_0000, 32'h0, 3, 0, 2, 1'b0, 16'h0000,
                32'h0100_0000, 32'h0, 8, 16'h0001, 8'h00};
    vecs[3] = '{32'h0300_0000, 32'h0, 0, 0, 0, 1'b1, 16'h0010,
                32'h0300_0000, 32'h0, 3, 16'h0010, 8'h00};
    vecs[4] = '{32'h0200_0005, 32'h0000_ABCD, 1, 2, 1, 1'b0, 16'h0000,
                32'h0200_0005, 32'h0000_ABCD, 8, 16'h0002, 8'h00};
    vecs[5] = '{32'h0100_0000, 32'h0, 0, 0, 1, 1'b1, 16'h0000,
                32'h0100_0000, 32'h0, 4, 16'h0000, 8'h02};

    for (int v = 0; v < 6; v++) begin
      mem[0] = vecs[v].w0;
      mem[1] = vecs[v].w1;
      do_reset();
      do_instr(16'h0000, vecs[v].w0c, vecs[v].w1c, vecs[v].ack, vecs[v].jv, vecs[v].ja,
               vecs[v].e_i0, vecs[v].e_i1, vecs[v].e_cyc, vecs[v].e_pc, vecs[v].e_cr);
    end

    // Two single-word instructions back to back.
    mem[0] = 32'h0100_0000;
    mem[1] = 32'h0300_0000;
    do_reset();
    do_instr(16'h0000, 0, 0, 0, 1'b0, 16'h0, 32'h0100_0000, 32'h0, 3, 16'h0001, 8'h00);
    do_instr(16'h0001, 0, 0, 0, 1'b0, 16'h0, 32'h0300_0000, 32'h0, 3, 16'h0002, 8'h00);

    // END: DECODE then HALT, and nothing but reset leaves HALT.
    mem[0] = 32'hF000_0000;
    do_reset();
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem[0];
    step();
    chk("end_decode_state", state, 4'd1);
    chk("end_decode_halted", halted, 1'b0);
    chk("end_decode_req", bus.mem_req, 1'b0);
    idle_inputs();
    step();
    chk("end_halted", halted, 1'b1);
    chk("end_cr", cr, 8'h01);
    chk("end_state", state, 4'd4);
    chk("end_valid", bus.instr_valid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus.mem_ready  = 1'($urandom);
      bus.mem_data   = $urandom;
      bus.ex_ack     = 1'($urandom);
      bus.jump_valid = 1'($urandom);
      bus.jump_addr  = 16'($urandom);
      step();
      chk("halt_stays", halted, 1'b1);
      chk("halt_no_req", bus.mem_req, 1'b0);
    end
    do_reset();

    // Asynchronous reset between edges while an instruction is offered.
    mem[0] = 32'h0100_0000;
    do_reset();
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem[0];
    step();
    idle_inputs();
    step();
    chk("exec_valid", bus.instr_valid, 1'b1);
    chk("exec_pc", pc, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.instr_valid, 1'b0);
    chk("async_pc", pc, 16'h0000);
    chk("async_state", state, 4'd0);
    do_reset();

    // pc wrap on a core whose reset pc is all-ones.
    chk("wrap_reset_pc", pc_w, 16'hFFFF);
    step();
    chk("wrap_pc", pc_w, 16'h0000);
    chk("wrap_state", state_w, 4'd1);

    // Randomized stream against the transaction-level model.
    mem[0] = 32'h0100_0000;
    do_reset();
    mpc = 16'h0000;
    mcr = 8'h00;
    for (int k = 0; k < 40; k++) begin
      w   = mem[mpc];
      two = (w[31:24] == 8'h02);
      i1  = two ? mem[16'(mpc + 16'd1)] : 32'h0;
      w0  = $urandom_range(0, 3);
      w1  = $urandom_range(0, 3);
      ak  = $urandom_range(0, 3);
      jv  = ($urandom_range(0, 3) == 0);
      ja  = ($urandom_range(0, 2) == 0) ? mpc : 16'($urandom_range(0, 60));
      ecyc = 3 + (two ? 1 + w1 : 0) + w0 + ak;
      npc  = jv ? ja : 16'(mpc + (two ? 16'd2 : 16'd1));
      if (jv && ja == mpc) mcr[1] = 1'b1;
      do_instr(mpc, w0, w1, ak, jv, ja, w, i1, ecyc, npc, mcr);
      mpc = npc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
